global_poly_fifo_mc: RTL and testbench

- Multi-client global polynomial FIFO holding FIFO_DEPTH polynomial slots, each one poly_ram_block, dual-ported A/B.
- Generalises the single-internal/single-AXI global input buffer to NUM_WR writers and NUM_RD readers (poly MAC, iNTT, AXI DMA, ...).
- Per-direction round-robin ownership grants, commit/abort semantics, occupancy count and sticky protocol-error flags.
- Sits between the top controller, the AXI conversion layer and the NTT/MAC datapath.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/poly_ram_block.sv | 33 +++
 rtl/rr_arbiter.sv | 48 ++++
 rtl/global_poly_fifo_mc.sv | 175 +++++++++++++++++
 tb/tb_global_poly_fifo_mc.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and widths for the multi-client global poly FIFO.
// Line geometry mirrors the common BIT_WIDTH/LINE_SIZE/ADDR_WIDTH set.
package fifo_pkg;

    localparam int BIT_WIDTH  = 16;
    localparam int LINE_SIZE  = 2;
    localparam int ADDR_WIDTH = 4;
    localparam int LINE_W     = BIT_WIDTH * LINE_SIZE;
    localparam int AW         = ADDR_WIDTH;

    typedef enum logic {W_IDLE, W_OWN} wr_state_t;
    typedef enum logic {R_IDLE, R_OWN} rd_state_t;

    function automatic logic multi_hot(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/poly_ram_block.sv
// Dual-port polynomial RAM, one line per port per cycle.
// Registered read data, read-before-write on the same port.
module poly_ram_block #(
    parameter int AW = 4,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          enA_i,
    input  logic          weA_i,
    input  logic [AW-1:0] addrA_i,
    input  logic [W-1:0]  dA_i,
    output logic [W-1:0]  qA_o,
    input  logic          enB_i,
    input  logic          weB_i,
    input  logic [AW-1:0] addrB_i,
    input  logic [W-1:0]  dB_i,
    output logic [W-1:0]  qB_o
);

    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (enA_i) begin
            if (weA_i) mem[addrA_i] <= dA_i;
            qA_o <= mem[addrA_i];
        end
        if (enB_i) begin
            if (weB_i) mem[addrB_i] <= dB_i;
            qB_o <= mem[addrB_i];
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Registered round-robin grant; priority moves past each winner.
// take_i latches the winner, drop_i clears the grant.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req_i,
    input  logic         take_i,
    input  logic         drop_i,
    output logic [N-1:0] gnt_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  gnt_q;
    logic [N-1:0]  win;
    logic [IW-1:0] prio_q;
    logic [IW-1:0] prio_d;

    always_comb begin
        win    = '0;
        prio_d = prio_q;
        // walk downward so the closest requester to prio_q wins
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[(int'(prio_q) + i) % N]) begin
                win    = '0;
                win[(int'(prio_q) + i) % N] = 1'b1;
                prio_d = IW'((int'(prio_q) + i + 1) % N);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            gnt_q  <= '0;
            prio_q <= '0;
        end else if (drop_i) begin
            gnt_q <= '0;
        end else if (take_i) begin
            gnt_q  <= win;
            prio_q <= prio_d;
        end
    end

    assign gnt_o = gnt_q;

endmodule

// File: rtl/global_poly_fifo_mc.sv
// Multi-client global poly FIFO: NUM_WR writers fill the tail slot,
// NUM_RD readers drain the head slot, each under exclusive ownership.
module global_poly_fifo_mc
    import fifo_pkg::*;
#(
    parameter int POINTER_WIDTH = 2,
    parameter int FIFO_DEPTH    = 2**POINTER_WIDTH,
    parameter int NUM_WR        = 2,
    parameter int NUM_RD        = 2,
    parameter int LINE_W        = fifo_pkg::LINE_W,
    parameter int AW            = fifo_pkg::AW
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NUM_WR-1:0]        wr_req,
    output logic [NUM_WR-1:0]        wr_gnt,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addrA,
    input  logic [NUM_WR*AW-1:0]     wr_addrB,
    input  logic [NUM_WR*LINE_W-1:0] wr_dA,
    input  logic [NUM_WR*LINE_W-1:0] wr_dB,
    input  logic [NUM_WR-1:0]        wr_done,
    input  logic [NUM_WR-1:0]        wr_abort,
    input  logic [NUM_RD-1:0]        rd_req,
    output logic [NUM_RD-1:0]        rd_gnt,
    input  logic [NUM_RD*AW-1:0]     rd_addrA,
    input  logic [NUM_RD*AW-1:0]     rd_addrB,
    output logic [LINE_W-1:0]        rd_dA,
    output logic [LINE_W-1:0]        rd_dB,
    input  logic [NUM_RD-1:0]        rd_done,
    input  logic [NUM_RD-1:0]        rd_abort,
    output logic [LINE_W-1:0]        tail_dA,
    output logic [LINE_W-1:0]        tail_dB,
    output logic                     full,
    output logic                     empty,
    output logic [POINTER_WIDTH:0]   count,
    output logic                     err_proto,
    input  logic                     err_clr
);

    localparam int PW = POINTER_WIDTH;

    wr_state_t         w_state_q;
    rd_state_t         r_state_q;
    logic [PW:0]       wr_ptr_q, rd_ptr_q;
    logic              err_q, rd_vld_q, tl_vld_q;
    logic [PW-1:0]     rd_slot_q, tl_slot_q;
    logic              w_own, r_own, w_we;
    logic              w_dn, w_ab, w_bad, w_take, w_rel;
    logic              r_dn, r_ab, r_bad, r_take, r_rel;
    logic [AW-1:0]     w_addrA, w_addrB, r_addrA, r_addrB;
    logic [LINE_W-1:0] w_dA, w_dB;
    logic [LINE_W-1:0] doA [FIFO_DEPTH];
    logic [LINE_W-1:0] doB [FIFO_DEPTH];

    assign w_own = w_state_q == W_OWN;
    assign r_own = r_state_q == R_OWN;
    assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign empty = wr_ptr_q == rd_ptr_q;
    assign count = wr_ptr_q - rd_ptr_q;

    always_comb begin
        w_addrA = '0;
        w_addrB = '0;
        w_dA    = '0;
        w_dB    = '0;
        r_addrA = '0;
        r_addrB = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_gnt[i]) begin
                w_addrA = wr_addrA[i*AW +: AW];
                w_addrB = wr_addrB[i*AW +: AW];
                w_dA    = wr_dA[i*LINE_W +: LINE_W];
                w_dB    = wr_dB[i*LINE_W +: LINE_W];
            end
        end
        for (int i = 0; i < NUM_RD; i++) begin
            if (rd_gnt[i]) begin
                r_addrA = rd_addrA[i*AW +: AW];
                r_addrB = rd_addrB[i*AW +: AW];
            end
        end
    end

    // grants are non-zero only while owning, so owner bits imply *_OWN
    assign w_we   = |(wr_en & wr_gnt);
    assign w_dn   = |(wr_done & wr_gnt);
    assign w_ab   = |(wr_abort & wr_gnt);
    assign w_rel  = w_dn ^ w_ab;
    assign w_take = !w_own && |wr_req && !full;
    assign w_bad  = |(wr_done & ~wr_gnt) | |(wr_abort & ~wr_gnt) |
                    |(wr_en & ~wr_gnt) | (w_dn & w_ab) |
                    multi_hot(32'(wr_done)) | multi_hot(32'(wr_abort));

    assign r_dn   = |(rd_done & rd_gnt);
    assign r_ab   = |(rd_abort & rd_gnt);
    assign r_rel  = r_dn ^ r_ab;
    assign r_take = !r_own && |rd_req && !empty;
    assign r_bad  = |(rd_done & ~rd_gnt) | |(rd_abort & ~rd_gnt) |
                    (r_dn & r_ab) |
                    multi_hot(32'(rd_done)) | multi_hot(32'(rd_abort));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_q     <= 1'b0;
            rd_vld_q  <= 1'b0;
            tl_vld_q  <= 1'b0;
            rd_slot_q <= '0;
            tl_slot_q <= '0;
        end else begin
            if (w_take)     w_state_q <= W_OWN;
            else if (w_rel) w_state_q <= W_IDLE;
            if (r_take)     r_state_q <= R_OWN;
            else if (r_rel) r_state_q <= R_IDLE;
            if (w_dn && !w_ab) wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
            if (r_dn && !r_ab) rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
            if (err_clr)             err_q <= 1'b0;
            else if (w_bad || r_bad) err_q <= 1'b1;
            rd_vld_q  <= r_own;
            rd_slot_q <= rd_ptr_q[PW-1:0];
            tl_vld_q  <= w_own;
            tl_slot_q <= wr_ptr_q[PW-1:0];
        end
    end

    assign err_proto = err_q;

    for (genvar s = 0; s < FIFO_DEPTH; s++) begin : g_slot
        logic sw, sr;
        assign sw = w_own && (wr_ptr_q[PW-1:0] == PW'(s));
        assign sr = !sw && r_own && (rd_ptr_q[PW-1:0] == PW'(s));
        poly_ram_block #(.AW(AW), .W(LINE_W)) u_ram (
            .clk     (clk),
            .enA_i   (sw | sr),
            .weA_i   (sw & w_we),
            .addrA_i (sw ? w_addrA : (sr ? r_addrA : '0)),
            .dA_i    (sw ? w_dA : '0),
            .qA_o    (doA[s]),
            .enB_i   (sw | sr),
            .weB_i   (sw & w_we),
            .addrB_i (sw ? w_addrB : (sr ? r_addrB : '0)),
            .dB_i    (sw ? w_dB : '0),
            .qB_o    (doB[s])
        );
    end

    rr_arbiter #(.N(NUM_WR)) u_wr_arb (
        .clk    (clk),
        .rstn   (rstn),
        .req_i  (wr_req),
        .take_i (w_take),
        .drop_i (w_rel),
        .gnt_o  (wr_gnt)
    );

    rr_arbiter #(.N(NUM_RD)) u_rd_arb (
        .clk    (clk),
        .rstn   (rstn),
        .req_i  (rd_req),
        .take_i (r_take),
        .drop_i (r_rel),
        .gnt_o  (rd_gnt)
    );

    assign rd_dA   = rd_vld_q ? doA[rd_slot_q] : '0;
    assign rd_dB   = rd_vld_q ? doB[rd_slot_q] : '0;
    assign tail_dA = tl_vld_q ? doA[tl_slot_q] : '0;
    assign tail_dB = tl_vld_q ? doB[tl_slot_q] : '0;

endmodule

// File: tb/tb_global_poly_fifo_mc.sv
// Scoreboard bench for global_poly_fifo_mc: directed traffic, read data
// checked by a monitor against an expectation queue.
module tb_global_poly_fifo_mc;
    import fifo_pkg::*;

    localparam int PW = 2;
    localparam int NW = 2;
    localparam int NR = 2;
    localparam int LW = fifo_pkg::LINE_W;
    localparam int A  = fifo_pkg::AW;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NW-1:0]     wr_req = '0, wr_gnt, wr_en = '0;
    logic [NW*A-1:0]   wr_addrA = '0, wr_addrB = '0;
    logic [NW*LW-1:0]  wr_dA = '0, wr_dB = '0;
    logic [NW-1:0]     wr_done = '0, wr_abort = '0;
    logic [NR-1:0]     rd_req = '0, rd_gnt;
    logic [NR*A-1:0]   rd_addrA = '0, rd_addrB = '0;
    logic [LW-1:0]     rd_dA, rd_dB, tail_dA, tail_dB;
    logic [NR-1:0]     rd_done = '0, rd_abort = '0;
    logic              full, empty, err_proto;
    logic              err_clr = 1'b0;
    logic [PW:0]       count;

    global_poly_fifo_mc #(
        .POINTER_WIDTH(PW), .NUM_WR(NW), .NUM_RD(NR)
    ) dut (
        .clk(clk), .rstn(rstn),
        .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_en(wr_en),
        .wr_addrA(wr_addrA), .wr_addrB(wr_addrB),
        .wr_dA(wr_dA), .wr_dB(wr_dB),
        .wr_done(wr_done), .wr_abort(wr_abort),
        .rd_req(rd_req), .rd_gnt(rd_gnt),
        .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
        .rd_dA(rd_dA), .rd_dB(rd_dB),
        .rd_done(rd_done), .rd_abort(rd_abort),
        .tail_dA(tail_dA), .tail_dB(tail_dB),
        .full(full), .empty(empty), .count(count),
        .err_proto(err_proto), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] a;
        logic [LW-1:0] b;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   vecs = 0;
    int   miss = 0;
    logic rd_issue = 1'b0;
    logic rd_pend  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        vecs++;
        if (act !== want) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) rd_pend <= rd_issue;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                vecs++;
                miss++;
                $display("FAIL rd_data: got %0h with nothing expected", rd_dA);
            end else begin
                e = exp_q.pop_front();
                chk("rd_dA", rd_dA, e.a);
                chk("rd_dB", rd_dB, e.b);
            end
        end
    end

    task automatic set_wr(input int c, input logic en, input logic [A-1:0] ad,
                          input logic [LW-1:0] da, input logic [LW-1:0] db);
        wr_en[c] = en;
        wr_addrA[c*A +: A] = ad;
        wr_addrB[c*A +: A] = ad + A'(8);
        wr_dA[c*LW +: LW] = da;
        wr_dB[c*LW +: LW] = db;
    endtask

    task automatic set_rd(input int c, input logic [A-1:0] ad,
                          input logic [LW-1:0] ea, input logic [LW-1:0] eb);
        exp_t x;
        x.a = ea;
        x.b = eb;
        exp_q.push_back(x);
        rd_addrA[c*A +: A] = ad;
        rd_addrB[c*A +: A] = ad + A'(8);
        rd_issue = 1'b1;
    endtask

    task automatic clr();
        wr_en = '0;
        wr_done = '0;
        wr_abort = '0;
        rd_done = '0;
        rd_abort = '0;
        rd_issue = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic wr_acq(input int c);
        wr_req[c] = 1'b1;
        tick();
        chk("wr_gnt_acq", wr_gnt, NW'(1) << c);
        wr_req[c] = 1'b0;
    endtask

    task automatic rd_acq(input int c);
        rd_req[c] = 1'b1;
        tick();
        chk("rd_gnt_acq", rd_gnt, NR'(1) << c);
        rd_req[c] = 1'b0;
    endtask

    task automatic wr_line(input int c, input logic [A-1:0] ad,
                           input logic [LW-1:0] da, input logic [LW-1:0] db);
        set_wr(c, 1'b1, ad, da, db);
        tick();
        clr();
    endtask

    task automatic rd_line(input int c, input logic [A-1:0] ad,
                           input logic [LW-1:0] ea, input logic [LW-1:0] eb);
        set_rd(c, ad, ea, eb);
        tick();
        clr();
    endtask

    task automatic wr_fin(input int c, input logic ab);
        if (ab) wr_abort[c] = 1'b1;
        else    wr_done[c]  = 1'b1;
        tick();
        clr();
        chk("wr_gnt_drop", wr_gnt, 0);
    endtask

    task automatic rd_fin(input int c, input logic ab);
        if (ab) rd_abort[c] = 1'b1;
        else    rd_done[c]  = 1'b1;
        tick();
        clr();
        chk("rd_gnt_drop", rd_gnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int o;
        repeat (2) tick();
        rstn = 1'b1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_wr_gnt", wr_gnt, 0);
        chk("rst_rd_gnt", rd_gnt, 0);
        chk("rst_err", err_proto, 0);
        chk("rst_rd_dA", rd_dA, 0);
        chk("rst_tail_dA", tail_dA, 0);

        // writer 0 fills four lines, tail read-back, reader 1 drains
        wr_acq(0);
        for (int i = 0; i < 4; i++)
            wr_line(0, A'(i), 32'hA000_0000 + i, 32'hB000_0000 + i);
        set_wr(0, 1'b0, A'(2), '0, '0);
        tick();
        chk("tail_dA", tail_dA, 32'hA000_0002);
        chk("tail_dB", tail_dB, 32'hB000_0002);
        clr();
        wr_fin(0, 1'b0);
        chk("count_after_commit", count, 1);
        chk("empty_after_commit", empty, 0);
        rd_acq(1);
        for (int i = 0; i < 4; i++)
            rd_line(1, A'(i), 32'hA000_0000 + i, 32'hB000_0000 + i);
        rd_fin(1, 1'b0);
        chk("count_after_pop", count, 0);
        chk("empty_after_pop", empty, 1);

        // both writers contend; writer 0 won last, so 1 goes first
        wr_req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (wr_gnt == '0 && n < 8) begin
                tick();
                n++;
            end
            chk("rr_gnt", wr_gnt, NW'(1) << ((k + 1) % 2));
            o = wr_gnt[1] ? 1 : 0;
            wr_line(o, '0, 32'hC000_0000 + k, 32'hD000_0000 + k);
            wr_done[o] = 1'b1;
            tick();
            clr();
        end
        chk("full_at_4", full, 1);
        chk("count_at_4", count, 4);
        repeat (3) tick();
        chk("no_gnt_when_full", wr_gnt, 0);
        wr_req = '0;
        for (int k = 0; k < 4; k++) begin
            rd_acq(0);
            rd_line(0, '0, 32'hC000_0000 + k, 32'hD000_0000 + k);
            rd_fin(0, 1'b0);
            if (k == 0) begin
                chk("full_after_pop", full, 0);
                chk("count_after_pop", count, 3);
            end
        end
        chk("empty_after_drain", empty, 1);

        // aborted write leaves slot free; next commit reuses it
        wr_acq(1);
        wr_line(1, A'(0), 32'h5A5A_0000, 32'h6B6B_0000);
        wr_line(1, A'(1), 32'h5A5A_0001, 32'h6B6B_0001);
        wr_fin(1, 1'b1);
        chk("count_after_abort", count, 0);
        chk("empty_after_abort", empty, 1);
        wr_acq(0);
        wr_line(0, A'(0), 32'hE000_0000, 32'hF000_0000);
        wr_fin(0, 1'b0);
        chk("count_reuse", count, 1);

        // reader abort then re-read of the same slot
        rd_acq(0);
        rd_line(0, A'(0), 32'hE000_0000, 32'hF000_0000);
        rd_fin(0, 1'b1);
        chk("count_after_rd_abort", count, 1);
        rd_acq(1);
        rd_line(1, A'(0), 32'hE000_0000, 32'hF000_0000);
        rd_line(1, A'(1), 32'h5A5A_0001, 32'h6B6B_0001);
        rd_fin(1, 1'b0);
        chk("empty_after_reread", empty, 1);

        // simultaneous commit and pop at count 2 across the wrap
        for (int k = 0; k < 2; k++) begin
            wr_acq(0);
            wr_line(0, A'(0), 32'h1111_0000 + k, 32'h2222_0000 + k);
            wr_fin(0, 1'b0);
        end
        chk("count_2", count, 2);
        wr_req[0] = 1'b1;
        rd_req[1] = 1'b1;
        tick();
        chk("both_wr_gnt", wr_gnt, 2'b01);
        chk("both_rd_gnt", rd_gnt, 2'b10);
        wr_req = '0;
        rd_req = '0;
        set_wr(0, 1'b1, A'(0), 32'h3333_0000, 32'h4444_0000);
        set_rd(1, A'(0), 32'h1111_0000, 32'h2222_0000);
        tick();
        clr();
        wr_done[0] = 1'b1;
        rd_done[1] = 1'b1;
        tick();
        clr();
        chk("count_same_cycle", count, 2);
        chk("full_same_cycle", full, 0);
        rd_acq(0);
        rd_line(0, A'(0), 32'h1111_0001, 32'h2222_0001);
        rd_fin(0, 1'b0);
        rd_acq(0);
        rd_line(0, A'(0), 32'h3333_0000, 32'h4444_0000);
        rd_fin(0, 1'b0);
        chk("count_after_wrap", count, 0);
        chk("empty_after_wrap", empty, 1);

        // protocol error: set, clear priority, clear
        wr_done[1] = 1'b1;
        tick();
        clr();
        chk("err_set", err_proto, 1);
        chk("err_no_ptr_move", count, 0);
        err_clr = 1'b1;
        rd_abort[0] = 1'b1;
        tick();
        clr();
        chk("err_clr_prio", err_proto, 0);
        rd_done[0] = 1'b1;
        tick();
        clr();
        chk("err_rd_set", err_proto, 1);
        err_clr = 1'b1;
        tick();
        clr();
        chk("err_clr", err_proto, 0);

        // reset while owning
        wr_acq(0);
        wr_line(0, A'(0), 32'h7777_0000, 32'h8888_0000);
        wr_fin(0, 1'b0);
        wr_acq(0);
        chk("count_pre_reset", count, 1);
        rstn = 1'b0;
        tick();
        chk("rst_own_gnt", wr_gnt, 0);
        chk("rst_own_count", count, 0);
        chk("rst_own_empty", empty, 1);
        rstn = 1'b1;
        repeat (2) tick();
        chk("sb_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
